// File: rtl/ram_arbiter.sv
// Two-port arbiter/sequencer in front of the scratch RAM.
// Each grant runs SETUP -> READ -> ACKS against the registered-read RAM.
module ram_arbiter #(
  parameter bit DBG_PRIORITY = 1'b0
) (
  input  logic       CLK,
  input  logic       RESETn,
  input  logic       CPU_REQ,
  input  logic       CPU_WE,
  input  logic [3:0] CPU_ADDR,
  input  logic [7:0] CPU_WDATA,
  output logic [7:0] CPU_RDATA,
  output logic       CPU_ACK,
  input  logic       DBG_REQ,
  input  logic       DBG_WE,
  input  logic [3:0] DBG_ADDR,
  input  logic [7:0] DBG_WDATA,
  output logic [7:0] DBG_RDATA,
  output logic       DBG_ACK,
  input  logic       DBG_LOCK,
  output logic [3:0] RAM_ADDR,
  output logic [7:0] RAM_DIN,
  output logic       RAM_RI,
  input  logic [7:0] RAM_DOUT,
  output logic       BUSY,
  output logic       OWNER
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    READ,
    ACKS
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic       we_q;
  logic       grant;
  logic       win;
  logic       cpu_ok;
  logic       dbg_ok;
  logic       win_we;
  logic [3:0] win_addr;
  logic [7:0] win_wdata;

  assign cpu_ok = CPU_REQ && !DBG_LOCK;
  assign dbg_ok = DBG_REQ;

  assign win_we    = win ? DBG_WE    : CPU_WE;
  assign win_addr  = win ? DBG_ADDR  : CPU_ADDR;
  assign win_wdata = win ? DBG_WDATA : CPU_WDATA;

  assign BUSY    = (state != IDLE);
  assign CPU_ACK = (state == ACKS) && !OWNER;
  assign DBG_ACK = (state == ACKS) && OWNER;

  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    win      = OWNER;
    unique case (state)
      IDLE: begin
        // On a tie, round-robin favours the port that did not go last.
        if (cpu_ok && dbg_ok) begin
          win = DBG_PRIORITY ? 1'b1 : ~OWNER;
        end else if (dbg_ok) begin
          win = 1'b1;
        end else if (cpu_ok) begin
          win = 1'b0;
        end
        if (cpu_ok || dbg_ok) begin
          grant    = 1'b1;
          state_nx = SETUP;
        end
      end
      SETUP:   state_nx = READ;
      READ:    state_nx = ACKS;
      ACKS:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state     <= IDLE;
      OWNER     <= 1'b1;
      we_q      <= 1'b0;
      RAM_ADDR  <= 4'h0;
      RAM_DIN   <= 8'h00;
      RAM_RI    <= 1'b0;
      CPU_RDATA <= 8'h00;
      DBG_RDATA <= 8'h00;
    end else begin
      state <= state_nx;
      if (grant) begin
        OWNER    <= win;
        we_q     <= win_we;
        RAM_ADDR <= win_addr;
        RAM_DIN  <= win_wdata;
        RAM_RI   <= win_we;
      end
      if (state == SETUP) begin
        RAM_RI <= 1'b0;
      end
      if (state == READ && !we_q) begin
        if (OWNER) begin
          DBG_RDATA <= RAM_DOUT;
        end else begin
          CPU_RDATA <= RAM_DOUT;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: round-robin and debug-priority instances side by
// side, each with its own RAM, checked against a transaction-level model.
module tb_ram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [1:0]      cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
  logic [1:0][3:0] cpu_addr, dbg_addr, ram_addr;
  logic [1:0][7:0] cpu_wdata, dbg_wdata, ram_din;
  logic [1:0][7:0] cpu_rdata, dbg_rdata;
  logic [1:0]      cpu_ack, dbg_ack, ram_ri, busy, owner;

  int  n_chk  = 0;
  int  n_fail = 0;
  bit  chk_on = 1'b0;

  function automatic logic [7:0] init_val(int i);
    logic [3:0] a;
    a = i[3:0];
    return {a, ~a};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [7:0] mem [16];
    logic [7:0] dout;

    initial begin
      for (int i = 0; i < 16; i++) mem[i] = init_val(i);
    end

    always @(posedge clk) begin
      if (ram_ri[g]) mem[ram_addr[g]] <= ram_din[g];
      dout <= mem[ram_addr[g]];
    end

    ram_arbiter #(.DBG_PRIORITY(g == 1)) u_dut (
      .CLK       (clk),
      .RESETn    (rst_n),
      .CPU_REQ   (cpu_req[g]),
      .CPU_WE    (cpu_we[g]),
      .CPU_ADDR  (cpu_addr[g]),
      .CPU_WDATA (cpu_wdata[g]),
      .CPU_RDATA (cpu_rdata[g]),
      .CPU_ACK   (cpu_ack[g]),
      .DBG_REQ   (dbg_req[g]),
      .DBG_WE    (dbg_we[g]),
      .DBG_ADDR  (dbg_addr[g]),
      .DBG_WDATA (dbg_wdata[g]),
      .DBG_RDATA (dbg_rdata[g]),
      .DBG_ACK   (dbg_ack[g]),
      .DBG_LOCK  (dbg_lock[g]),
      .RAM_ADDR  (ram_addr[g]),
      .RAM_DIN   (ram_din[g]),
      .RAM_RI    (ram_ri[g]),
      .RAM_DOUT  (dout),
      .BUSY      (busy[g]),
      .OWNER     (owner[g])
    );
  end

  // Reference: each grant is a 3-cycle transaction; cycles since grant
  // (0 = idle) determine every output.
  int         m_age [2];
  logic       m_own [2];
  logic       m_we  [2];
  logic [3:0] m_addr[2];
  logic [7:0] m_din [2];
  logic [7:0] m_rd  [2];
  logic [7:0] m_crd [2];
  logic [7:0] m_drd [2];
  logic [7:0] m_mem [2][16];

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_age[k] = 0;
      for (int i = 0; i < 16; i++) m_mem[k][i] = init_val(i);
    end
  end

  always @(posedge clk) begin
    bit ec, ed, w;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_age[k] = 0;   m_own[k] = 1'b1; m_we[k]  = 1'b0;
        m_addr[k] = '0; m_din[k] = '0;
        m_crd[k] = '0;  m_drd[k] = '0;
      end else if (m_age[k] == 0) begin
        ec = cpu_req[k] && !dbg_lock[k];
        ed = dbg_req[k];
        if (ec || ed) begin
          if (ec && ed) w = (k == 1) ? 1'b1 : !m_own[k];
          else          w = ed;
          m_own[k]  = w;
          m_we[k]   = w ? dbg_we[k]    : cpu_we[k];
          m_addr[k] = w ? dbg_addr[k]  : cpu_addr[k];
          m_din[k]  = w ? dbg_wdata[k] : cpu_wdata[k];
          if (m_we[k]) m_mem[k][m_addr[k]] = m_din[k];
          else         m_rd[k] = m_mem[k][m_addr[k]];
          m_age[k] = 1;
        end
      end else begin
        if (m_age[k] == 2 && !m_we[k]) begin
          if (m_own[k]) m_drd[k] = m_rd[k];
          else          m_crd[k] = m_rd[k];
        end
        m_age[k] = (m_age[k] + 1) % 4;
      end
    end
  end

  task automatic chk(string nm, int k, logic [7:0] act, logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %h expected %h t=%0t",
               nm, k, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 2; k++) begin
        chk("busy",  k, 8'(busy[k]),  8'(m_age[k] != 0));
        chk("owner", k, 8'(owner[k]), 8'(m_own[k]));
        chk("raddr", k, 8'(ram_addr[k]), 8'(m_addr[k]));
        chk("rdin",  k, ram_din[k], m_din[k]);
        chk("ri",    k, 8'(ram_ri[k]), 8'(m_age[k] == 1 && m_we[k]));
        chk("cack",  k, 8'(cpu_ack[k]), 8'(m_age[k] == 3 && !m_own[k]));
        chk("dack",  k, 8'(dbg_ack[k]), 8'(m_age[k] == 3 && m_own[k]));
        chk("crd",   k, cpu_rdata[k], m_crd[k]);
        chk("drd",   k, dbg_rdata[k], m_drd[k]);
      end
    end
  end

  task automatic set_cpu(logic r, logic w, logic [3:0] a, logic [7:0] d);
    cpu_req = {r, r}; cpu_we = {w, w}; cpu_addr = {a, a}; cpu_wdata = {d, d};
  endtask

  task automatic set_dbg(logic r, logic w, logic [3:0] a, logic [7:0] d);
    dbg_req = {r, r}; dbg_we = {w, w}; dbg_addr = {a, a}; dbg_wdata = {d, d};
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    set_cpu(0, 0, 0, 0);
    set_dbg(0, 0, 0, 0);
    dbg_lock = 2'b00;
    tick(2);
    chk_on = 1'b1;
    chk("rst_busy",  0, 8'(busy[0]), 8'h00);
    chk("rst_owner", 0, 8'(owner[0]), 8'h01);
    chk("rst_crd",   0, cpu_rdata[0], 8'h00);
    chk("rst_raddr", 0, 8'(ram_addr[0]), 8'h00);

    // CPU read of 0x3
    rst_n = 1'b1;
    set_cpu(1, 0, 4'h3, 8'h00);
    tick(1);
    chk("t1_addr_c1", 0, 8'(ram_addr[0]), 8'h03);
    chk("t1_ri_c1",   0, 8'(ram_ri[0]), 8'h00);
    tick(1);
    chk("t1_addr_c2", 0, 8'(ram_addr[0]), 8'h03);
    chk("t1_ack_c2",  0, 8'(cpu_ack[0]), 8'h00);
    tick(1);
    chk("t1_ack_c3",  0, 8'(cpu_ack[0]), 8'h01);
    chk("t1_dack_c3", 0, 8'(dbg_ack[0]), 8'h00);
    chk("t1_rdata",   0, cpu_rdata[0], 8'h3C);
    set_cpu(0, 0, 0, 0);
    tick(1);
    chk("t1_ack_c4",  0, 8'(cpu_ack[0]), 8'h00);

    // debug write 0xA5 to 0xC, then CPU read-back
    set_dbg(1, 1, 4'hC, 8'hA5);
    tick(1);
    chk("t2_ri_c1",  0, 8'(ram_ri[0]), 8'h01);
    chk("t2_din_c1", 0, ram_din[0], 8'hA5);
    tick(1);
    chk("t2_ri_c2",  0, 8'(ram_ri[0]), 8'h00);
    tick(1);
    chk("t2_dack",   0, 8'(dbg_ack[0]), 8'h01);
    set_dbg(0, 0, 0, 0);
    set_cpu(1, 0, 4'hC, 8'h00);
    tick(4);
    chk("t2_rb_ack", 0, 8'(cpu_ack[0]), 8'h01);
    chk("t2_rb",     0, cpu_rdata[0], 8'hA5);
    set_cpu(0, 0, 0, 0);

    // REQ dropped and fields changed after grant
    tick(1);
    set_cpu(1, 0, 4'h1, 8'h00);
    tick(1);
    set_cpu(0, 1, 4'h7, 8'hFF);
    tick(2);
    chk("t2v_ack",   0, 8'(cpu_ack[0]), 8'h01);
    chk("t2v_rdata", 0, cpu_rdata[0], 8'h1E);

    // both requesting continuously
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    set_cpu(1, 0, 4'h1, 8'h00);
    set_dbg(1, 0, 4'h2, 8'h00);
    for (int t = 0; t < 6; t++) begin
      tick(t == 0 ? 3 : 4);
      chk("rr_cack", 0, 8'(cpu_ack[0]), 8'(t % 2 == 0));
      chk("rr_dack", 0, 8'(dbg_ack[0]), 8'(t % 2 == 1));
      chk("rr_own",  0, 8'(owner[0]), 8'(t % 2));
      chk("pr_dack", 1, 8'(dbg_ack[1]), 8'h01);
    end
    set_dbg(0, 0, 0, 0);
    tick(4);
    chk("pr_cack", 1, 8'(cpu_ack[1]), 8'h01);
    chk("rr_cack_end", 0, 8'(cpu_ack[0]), 8'h01);
    chk("rr_crd", 0, cpu_rdata[0], 8'h1E);
    chk("rr_drd", 0, dbg_rdata[0], 8'h2D);
    chk("pr_drd", 1, dbg_rdata[1], 8'h2D);
    set_cpu(0, 0, 0, 0);

    // lock stalls CPU
    tick(1);
    dbg_lock = 2'b11;
    set_cpu(1, 0, 4'h4, 8'h00);
    repeat (20) begin
      tick(1);
      chk("lk_busy", 0, 8'(busy[0]), 8'h00);
      chk("lk_cack", 0, 8'(cpu_ack[0]), 8'h00);
    end
    dbg_lock = 2'b00;
    tick(3);
    chk("lk_ack",   0, 8'(cpu_ack[0]), 8'h01);
    chk("lk_rdata", 0, cpu_rdata[0], 8'h4B);
    set_cpu(0, 0, 0, 0);

    // reset during READ
    tick(1);
    set_cpu(1, 0, 4'h5, 8'h00);
    tick(2);
    rst_n = 1'b0;
    tick(1);
    chk("rs_cack", 0, 8'(cpu_ack[0]), 8'h00);
    chk("rs_crd",  0, cpu_rdata[0], 8'h00);
    chk("rs_ri",   0, 8'(ram_ri[0]), 8'h00);
    chk("rs_busy", 0, 8'(busy[0]), 8'h00);
    rst_n = 1'b1;
    tick(3);
    chk("rs_ack2", 0, 8'(cpu_ack[0]), 8'h01);
    chk("rs_rd2",  0, cpu_rdata[0], 8'h5A);
    set_cpu(0, 0, 0, 0);

    // random traffic, independent requesters per instance
    tick(1);
    repeat (2000) begin
      tick(1);
      for (int k = 0; k < 2; k++) begin
        if (!cpu_req[k] || cpu_ack[k]) begin
          cpu_req[k]   = ($urandom_range(0, 2) != 0);
          cpu_we[k]    = 1'($urandom_range(0, 1));
          cpu_addr[k]  = 4'($urandom);
          cpu_wdata[k] = 8'($urandom);
        end
        if (!dbg_req[k] || dbg_ack[k]) begin
          dbg_req[k]   = ($urandom_range(0, 2) != 0);
          dbg_we[k]    = 1'($urandom_range(0, 1));
          dbg_addr[k]  = 4'($urandom);
          dbg_wdata[k] = 8'($urandom);
        end
        if ($urandom_range(0, 19) == 0) dbg_lock[k] = ~dbg_lock[k];
      end
    end
    set_cpu(0, 0, 0, 0);
    set_dbg(0, 0, 0, 0);
    dbg_lock = 2'b00;
    tick(8);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the 16-byte, two-bank scratch RAM.
- The CPU port and a debug/loader port share the RAM's single ADDR/DIN/DOUT/RI interface.
- Each granted access is sequenced through the RAM's registered-read timing, and read data is returned on the owning port with a one-cycle ACK.
- Sits between the CPU core, the external loader and the RAM instance.

Parameters:
- DBG_PRIORITY, 0: 0 = round-robin between ports; 1 = debug port always wins a tie.

Ports:
- CLK  in  1  system clock; all state updates on rising edge
- RESETn  in  1  synchronous reset, active low
- CPU_REQ  in  1  CPU access request; held with fields stable until CPU_ACK
- CPU_WE  in  1  1 = write, 0 = read
- CPU_ADDR  in  4  RAM byte address
- CPU_WDATA  in  8  write data
- CPU_RDATA  out  8  last read data for CPU port (registered)
- CPU_ACK  out  1  one-cycle completion pulse
- DBG_REQ  in  1  debug/loader request; same protocol as CPU_REQ
- DBG_WE  in  1  1 = write, 0 = read
- DBG_ADDR  in  4  RAM byte address
- DBG_WDATA  in  8  write data
- DBG_RDATA  out  8  last read data for debug port (registered)
- DBG_ACK  out  1  one-cycle completion pulse
- DBG_LOCK  in  1  1 = debug port holds exclusive ownership; CPU_REQ never granted
- RAM_ADDR  out  4  to RAM ADDR
- RAM_DIN  out  8  to RAM DIN
- RAM_RI  out  1  to RAM RI (write strobe)
- RAM_DOUT  in  8  from RAM DOUT; valid the cycle after RAM_ADDR is applied
- BUSY  out  1  1 whenever state != IDLE
- OWNER  out  1  0 = CPU, 1 = debug; owner of current or last transaction

Behaviour:
- Reset (RESETn low at a rising edge): state IDLE; CPU_RDATA = DBG_RDATA = 0; both ACKs 0; RAM_ADDR = 0; RAM_DIN = 0; RAM_RI = 0; BUSY = 0; OWNER = 1, so the CPU wins the first tie. Applies mid-transaction: the in-flight access is abandoned with no ACK. A write cut off in SETUP may or may not land in RAM.
- All outputs are registered or decoded from state registers only; no combinational input-to-output paths.
- State machine: IDLE -> SETUP -> READ -> ACKS -> IDLE. Fixed latency: a request seen in IDLE at edge N gives ACK high in cycle N+3. Peak throughput is one access per 4 cycles.
- IDLE: eligible requests are DBG_REQ, plus CPU_REQ when DBG_LOCK = 0.
  - None eligible: stay in IDLE.
  - Exactly one eligible: it wins.
  - Both eligible: with DBG_PRIORITY = 1, debug wins. With DBG_PRIORITY = 0, the port not equal to OWNER wins (round-robin).
  - On grant: latch WE, ADDR and WDATA of the winner; OWNER <= winner; RAM_ADDR <= addr; RAM_DIN <= wdata; RAM_RI <= we; go to SETUP.
- SETUP: RAM_RI high only if write; RAM_ADDR and RAM_DIN held. At the edge, RAM_RI <= 0; go to READ.
- READ: RAM_DOUT is valid. At the edge, on a read, the owner's RDATA <= RAM_DOUT. The other port's RDATA is never touched; writes update no RDATA. Go to ACKS.
- ACKS: the owner's ACK = 1 for exactly this cycle; the other port's ACK = 0. Go to IDLE unconditionally.
- Requester may change REQ and fields at the edge ending its ACK cycle. The next IDLE samples the new values, so back-to-back transactions are never re-granted twice on stale REQ.
- Fields are latched at grant; changes to ADDR, WE or WDATA after grant are ignored.
- REQ dropped before ACK (protocol violation): the transaction still completes and ACK is still issued.
- DBG_LOCK is sampled only in IDLE. Asserting it mid-transaction does not abort a CPU access. A waiting CPU_REQ stalls indefinitely while the lock is held.
- RAM_RI is never high outside SETUP.
- RAM_ADDR and RAM_DIN hold their last values in IDLE.
- All 16 addresses are legal; no wrap or range check is needed.

Test Plan:
- Reset, then CPU read of addr 0x3: CPU_REQ = 1 at cycle 0. Required: RAM_ADDR = 3 in cycles 1-2, RAM_RI = 0 throughout, CPU_ACK high in cycle 3 only, CPU_RDATA = RAM contents, DBG_ACK = 0.
- Debug write 0xA5 to addr 0xC: RAM_RI high exactly in cycle 1 with RAM_DIN = 0xA5, DBG_ACK in cycle 3. A follow-up CPU read of 0xC returns 0xA5 (exercises bank 1).
- Both REQ high continuously, DBG_PRIORITY = 0, 6 transactions: grants alternate CPU, DBG, CPU, ...; ACK every 4 cycles; OWNER toggles.
- Same stimulus with DBG_PRIORITY = 1: all grants go to debug while DBG_REQ stays high; the CPU is granted only after DBG_REQ drops.
- DBG_LOCK = 1 with CPU_REQ = 1 for 20 cycles: no CPU_ACK, BUSY = 0. Dropping the lock gives CPU_ACK exactly 3 cycles after the next IDLE sample.
- RESETn low during READ of a CPU read: no CPU_ACK, CPU_RDATA = 0, RAM_RI = 0, BUSY = 0. After release, the still-held CPU_REQ is granted and completes normally.
